audio_i2s_tx: RTL and testbench
===============================

# audio_i2s_tx

Consumer end of the synth's summed-tone path. Takes the 32-bit mixed sample produced by the voice datapath and stores it in a one-entry holding register, saturated to 16 bits. At every frame start it requests the next sample. It serializes each sample as a mono (L = R) 16-bit I2S stream to the board audio codec, generating BCLK and LRCLK from the system clock.

## Interface
- BCLK_HALF, 8: CLK cycles per BCLK half-period (≥2); BCLK = CLK/(2·BCLK_HALF)
- SHIFT, 15: arithmetic right shift applied to TONE before 16-bit saturation (0..16)
- CLK  in  1  system clock; all logic on rising edge
- RESET  in  1  synchronous, active-high reset
- TONE  in  32  signed mixed sample from voice datapath
- TONE_VALID  in  1  one-cycle strobe: TONE is a complete sample
- CLR_FLAGS  in  1  clears OVERFLOW/UNDERRUN
- SAMPLE_REQ  out  1  one-cycle pulse: start computing next sample
- AUD_BCLK  out  1  I2S bit clock
- AUD_DACLRCK  out  1  I2S word select; 0 = left
- AUD_DACDAT  out  1  I2S serial data, MSB first
- OVERFLOW  out  1  sticky: sample overwritten in holding register
- UNDERRUN  out  1  sticky: frame started with holding register empty

## Operation
- Reset values: AUD_BCLK=0, AUD_DACLRCK=0, AUD_DACDAT=0, SAMPLE_REQ=0, OVERFLOW=0, UNDERRUN=0. Divider=0, bit counter=0, holding empty, output word S=0, "started" flag=0.
- Clock gen: the divider counts 0..BCLK_HALF-1. At BCLK_HALF-1 it wraps and AUD_BCLK toggles. Toggle 1→0 is a "fall event".
- Bit counter b (6 bits, 0..63) increments on each fall event and wraps 63→0. AUD_DACLRCK = b[5], registered.
- Frame-start event: the fall event where b goes 63→0. At that event:
  - If holding is full: S ← holding and holding becomes empty.
  - If holding is empty: S is kept (last sample repeats) and UNDERRUN sets if started=1.
  - SAMPLE_REQ pulses on the following cycle.
- SAMPLE_REQ also pulses once, on the first cycle after RESET deasserts.
- Data: AUD_DACDAT updates on every fall event from the new b. With n = b[4:0], DACDAT = S[16-n] for n=1..16, else 0. This gives I2S one-BCLK delay after the LRCLK edge, with the same S on both channels.
- Acceptance on TONE_VALID:
  - x = TONE >>> SHIFT (sign-preserving).
  - Holding ← 0x7FFF if x > 32767, 0x8000 if x < -32768, else x[15:0]. Holding becomes full and started ← 1.
- Simultaneous TONE_VALID and frame start:
  - The transfer uses the old holding content. The new sample then fills holding.
  - If holding was empty, underrun handling applies. There is no bypass.
- Overflow: TONE_VALID while holding is full and no transfer happens that cycle. The new sample overwrites (latest wins) and OVERFLOW sets.
- CLR_FLAGS clears both flags. A set event in the same cycle wins.
- RESET asserted mid-frame returns everything to reset values on the next edge. Pending holding data is discarded.

## Timing
- Cycles are counted from the first cycle with RESET=0 (cycle 0).
- First BCLK rise at cycle BCLK_HALF. First fall at 2·BCLK_HALF.
- BCLK period is 2·BCLK_HALF; frame is 128·BCLK_HALF cycles (1024 at default).
- First frame start is at the 64th fall event (cycle 1024 at default); SAMPLE_REQ follows at cycle 1025.
- TONE_VALID at cycle t → holding full at t+1.
- The MSB appears on AUD_DACDAT one BCLK after the next frame start. Worst-case latency is one frame plus one BCLK period.
- DACDAT and LRCLK change only on fall events; they are stable around BCLK rising edges.
- Both flags are visible the cycle after the causing event.

## Test plan
- Reset/idle: release RESET, no TONE_VALID → SAMPLE_REQ high at cycle 0 only. BCLK toggles every 8 cycles. LRCLK=0 for cycles 0..511 and 1 thereafter. DACDAT stays 0. UNDERRUN stays 0 (not started).
- Basic serialization, default params: TONE=0x00012345 at cycle 100 → S=0x0002 at the cycle-1024 frame start. DACDAT shows 0x0002 MSB-first in n=1..16 of both channels. SAMPLE_REQ pulses at cycle 1025.
- Saturation: TONE 0x7FFFFFFF → 0x7FFF; 0x80000000 → 0x8000; 0xFFFF8000 → 0xFFFF; 0x00007FFF → 0x0000.
- Overflow and simultaneity: two TONE_VALIDs mid-frame → OVERFLOW=1 and the second sample is sent. A TONE_VALID on the exact frame-start cycle with holding full → old sample sent, new sample held, no OVERFLOW.
- Underrun: after one sample is sent, supply none for the next frame → UNDERRUN=1 and the same S repeats. CLR_FLAGS together with a new underrun leaves UNDERRUN=1.
- Reset mid-frame: assert RESET at cycle 700 with holding full → next cycle all outputs at reset values and holding empty. The frame restarts from cycle 0 timing.

Source files
------------

// File: rtl/audio_i2s_tx_if.sv
// audio_i2s_tx_if: sample handshake, flag control and I2S pins of the tone transmitter
interface audio_i2s_tx_if;
  logic [31:0] tone;
  logic        tone_valid;
  logic        clr_flags;
  logic        sample_req;
  logic        aud_bclk;
  logic        aud_daclrck;
  logic        aud_dacdat;
  logic        overflow;
  logic        underrun;
  modport master (
    output tone, tone_valid, clr_flags,
    input  sample_req, aud_bclk, aud_daclrck, aud_dacdat, overflow, underrun
  );
  modport slave (
    input  tone, tone_valid, clr_flags,
    output sample_req, aud_bclk, aud_daclrck, aud_dacdat, overflow, underrun
  );
endinterface

// File: rtl/audio_i2s_tx.sv
// audio_i2s_tx: saturating one-entry sample holder feeding a mono 16-bit I2S serializer
module audio_i2s_tx #(
  parameter int BCLK_HALF = 8,
  parameter int SHIFT     = 15
) (
  input logic clk,
  input logic rst,
  audio_i2s_tx_if.slave bus
);
  localparam int DW = $clog2(BCLK_HALF);
  logic [DW-1:0] div;
  logic [5:0] b, b_nx;
  logic [4:0] idx;
  logic [15:0] s, hold, sat;
  logic signed [31:0] x;
  logic bclk, full, started, first, frame_d, req_q, dat, ovf, und;
  logic wrap, fall, frame;
  always_comb begin
    wrap  = div == DW'(BCLK_HALF - 1);
    fall  = wrap & bclk;
    frame = fall & (b == 6'd63);
    b_nx  = b + 6'd1;
    idx   = 5'd16 - b_nx[4:0];
    x     = $signed(bus.tone) >>> SHIFT;
    sat   = x > 32'sd32767 ? 16'h7fff : x < -32'sd32768 ? 16'h8000 : x[15:0];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      div     <= '0;
      bclk    <= 1'b0;
      b       <= '0;
      s       <= '0;
      hold    <= '0;
      full    <= 1'b0;
      started <= 1'b0;
      first   <= 1'b1;
      frame_d <= 1'b0;
      req_q   <= 1'b0;
      dat     <= 1'b0;
      ovf     <= 1'b0;
      und     <= 1'b0;
    end else begin
      div <= wrap ? '0 : div + 1'b1;
      if (wrap) bclk <= ~bclk;
      if (fall) begin
        b   <= b_nx;
        dat <= (b_nx[4:0] != 5'd0 && b_nx[4:0] <= 5'd16) ? s[idx[3:0]] : 1'b0;
      end
      first   <= 1'b0;
      frame_d <= frame;
      req_q   <= frame_d;
      // transfer reads the old holding value even when a new sample lands this cycle
      if (frame && full) s <= hold;
      full <= bus.tone_valid | (full & ~frame);
      if (bus.tone_valid) begin
        hold    <= sat;
        started <= 1'b1;
      end
      ovf <= (bus.tone_valid & full & ~frame) | (ovf & ~bus.clr_flags);
      und <= (frame & ~full & started) | (und & ~bus.clr_flags);
    end
  end
  assign bus.sample_req  = req_q | (first & ~rst);
  assign bus.aud_bclk    = bclk;
  assign bus.aud_daclrck = b[5];
  assign bus.aud_dacdat  = dat;
  assign bus.overflow    = ovf;
  assign bus.underrun    = und;
endmodule

// File: tb/tb_audio_i2s_tx.sv
// tb_audio_i2s_tx: directed checks of clocking, saturation, serialization and flags
module tb_audio_i2s_tx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int passed = 0;
  int total = 0;
  int r;
  logic [15:0] w;
  logic [31:0] tv [4];
  logic [15:0] te [4];
  audio_i2s_tx_if bus ();
  audio_i2s_tx #(.BCLK_HALF(8), .SHIFT(15)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic go_to(input int n);
    while (cyc < n) step();
  endtask
  task automatic send(input int t, input logic [31:0] v);
    go_to(t);
    bus.tone = v;
    bus.tone_valid = 1'b1;
    step();
    bus.tone_valid = 1'b0;
  endtask
  task automatic clr(input int t);
    go_to(t);
    bus.clr_flags = 1'b1;
    step();
    bus.clr_flags = 1'b0;
  endtask
  task automatic rd(input int f, input int base, output logic [15:0] wd);
    wd = '0;
    for (int i = 1; i <= 16; i++) begin
      go_to(f + 16 * (base + i) + 8);
      wd = {wd[14:0], bus.aud_dacdat};
    end
  endtask
  initial begin
    tv[0] = 32'h7FFFFFFF; te[0] = 16'h7FFF;
    tv[1] = 32'h80000000; te[1] = 16'h8000;
    tv[2] = 32'hFFFF8000; te[2] = 16'hFFFF;
    tv[3] = 32'h00007FFF; te[3] = 16'h0000;
    bus.tone = '0;
    bus.tone_valid = 1'b0;
    bus.clr_flags = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    cyc = 0;
    #1;
    chk("req_c0", bus.sample_req, 1);
    chk("bclk_c0", bus.aud_bclk, 0);
    chk("lrck_c0", bus.aud_daclrck, 0);
    chk("dat_c0", bus.aud_dacdat, 0);
    chk("ovf_c0", bus.overflow, 0);
    chk("und_c0", bus.underrun, 0);
    step();
    chk("req_c1", bus.sample_req, 0);
    go_to(7);  chk("bclk_c7", bus.aud_bclk, 0);
    go_to(8);  chk("bclk_c8", bus.aud_bclk, 1);
    go_to(15); chk("bclk_c15", bus.aud_bclk, 1);
    go_to(16); chk("bclk_c16", bus.aud_bclk, 0);
    send(100, 32'h00012345);
    go_to(511); chk("lrck_c511", bus.aud_daclrck, 0);
    go_to(512); chk("lrck_c512", bus.aud_daclrck, 1);
    go_to(600); chk("dat_idle", bus.aud_dacdat, 0);
    go_to(1023); chk("req_c1023", bus.sample_req, 0);
    go_to(1024); chk("req_c1024", bus.sample_req, 0);
    chk("lrck_c1024", bus.aud_daclrck, 0);
    go_to(1025); chk("req_c1025", bus.sample_req, 1);
    go_to(1026); chk("req_c1026", bus.sample_req, 0);
    rd(1024, 0, w);  chk("word_l1", w, 16'h0002);
    rd(1024, 32, w); chk("word_r1", w, 16'h0002);
    chk("und_f1", bus.underrun, 0);
    for (int i = 0; i < 4; i++) begin
      send(1024 * (i + 2) - 100, tv[i]);
      rd(1024 * (i + 2), 0, w);
      chk($sformatf("sat_%0d", i), w, te[i]);
      chk($sformatf("sat_und_%0d", i), bus.underrun, 0);
    end
    send(5500, 32'h00010000);
    chk("ovf_before", bus.overflow, 0);
    send(5510, 32'h00030000);
    chk("ovf_set", bus.overflow, 1);
    rd(6144, 0, w); chk("ovf_latest", w, 16'h0006);
    chk("und_f6", bus.underrun, 0);
    clr(6500);
    chk("ovf_clr", bus.overflow, 0);
    send(7000, 32'h00050000);
    send(7167, 32'h00070000);
    chk("simul_no_ovf", bus.overflow, 0);
    rd(7168, 0, w); chk("simul_old", w, 16'h000A);
    rd(8192, 0, w); chk("simul_new", w, 16'h000E);
    chk("und_f8", bus.underrun, 0);
    go_to(9215); chk("und_pre", bus.underrun, 0);
    go_to(9216); chk("und_set", bus.underrun, 1);
    rd(9216, 0, w); chk("und_repeat", w, 16'h000E);
    clr(9500);
    chk("und_clr", bus.underrun, 0);
    clr(10239);
    chk("und_clr_lose", bus.underrun, 1);
    send(10300, 32'h00090000);
    go_to(10939); chk("lrck_pre_rst", bus.aud_daclrck, 1);
    step();
    rst = 1'b1;
    step();
    chk("rst_req", bus.sample_req, 0);
    chk("rst_bclk", bus.aud_bclk, 0);
    chk("rst_lrck", bus.aud_daclrck, 0);
    chk("rst_dat", bus.aud_dacdat, 0);
    chk("rst_und", bus.underrun, 0);
    chk("rst_ovf", bus.overflow, 0);
    rst = 1'b0;
    #1;
    r = cyc;
    chk("rst_req_rel", bus.sample_req, 1);
    go_to(r + 1); chk("rst_req_r1", bus.sample_req, 0);
    go_to(r + 7); chk("rst_bclk_r7", bus.aud_bclk, 0);
    go_to(r + 8); chk("rst_bclk_r8", bus.aud_bclk, 1);
    go_to(r + 1024); chk("rst_no_und", bus.underrun, 0);
    go_to(r + 1025); chk("rst_req_frame", bus.sample_req, 1);
    rd(r + 1024, 0, w); chk("rst_discard", w, 16'h0000);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
